// File: rtl/adc_serial_rx.sv
// Stereo serial-audio receiver for the PCM4202 in slave mode: oversamples BCK/LRCK/DATA
// in i_clk, decodes left-justified or I2S frames and hands out left/right pairs via valid/ready.
//
//  state   | meaning
//  S_IDLE  | not framed; waiting for slot level to change to left
//  S_LEFT  | shifting bits of the left slot
//  S_RIGHT | shifting bits of the right slot; next left edge completes the frame
module adc_serial_rx #(
   parameter int DATA_W      = 24,
   parameter int MODE        = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_bck,
   input  logic              i_lrck,
   input  logic              i_serial_data,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_left_sample,
   output logic [DATA_W-1:0] o_right_sample,
   output logic              o_valid,
   output logic              o_frame_err,
   output logic              o_overrun,
   output logic              o_locked
);
   localparam int               CNT_W      = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] TOP_POS    = CNT_W'(DATA_W - 1);
   localparam logic [12:0]      STALL_LOAD = 13'd4096;

   typedef enum logic [1:0] {S_IDLE, S_LEFT, S_RIGHT} state_t;
   state_t state_q, state_nx;

   logic [SYNC_STAGES-1:0] bck_sync, lrck_sync, data_sync;
   logic                   bck_s, lrck_s, data_s, bck_prev, bck_rise;
   logic                   lrck_d, slot_lvl, lvl_prev;
   logic [12:0]            stall_cnt;
   logic [CNT_W-1:0]       cnt_q, cnt_nx;
   logic [DATA_W-1:0]      lsr_q, lsr_nx, rsr_q, rsr_nx, bit_word, msb_word;
   logic                   err_q, err_nx, done_nx, done_q;
   logic [DATA_W-1:0]      pair_l, pair_r;
   logic                   pair_err;

   assign bck_s    = bck_sync[SYNC_STAGES-1];
   assign lrck_s   = lrck_sync[SYNC_STAGES-1];
   assign data_s   = data_sync[SYNC_STAGES-1];
   assign bck_rise = bck_s & ~bck_prev;
   // I2S: LRCK delayed by one BCK lines the slot boundary up with the MSB, and left is low
   assign slot_lvl = (MODE == 0) ? lrck_s : ~lrck_d;
   assign bit_word = {{(DATA_W-1){1'b0}}, data_s} << (TOP_POS - cnt_q);
   assign msb_word = {data_s, {(DATA_W-1){1'b0}}};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bck_sync  <= '0;
         lrck_sync <= '0;
         data_sync <= '0;
         bck_prev  <= 1'b0;
         lrck_d    <= 1'b0;
         lvl_prev  <= 1'b1;
         stall_cnt <= STALL_LOAD;
      end else begin
         bck_sync  <= {bck_sync[SYNC_STAGES-2:0], i_bck};
         lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], i_lrck};
         data_sync <= {data_sync[SYNC_STAGES-2:0], i_serial_data};
         bck_prev  <= bck_s;
         if (bck_rise) begin
            lrck_d    <= lrck_s;
            lvl_prev  <= slot_lvl;
            stall_cnt <= STALL_LOAD;
         end else if (stall_cnt != '0) begin
            stall_cnt <= stall_cnt - 13'd1;
         end
      end
   end

   always_comb begin
      state_nx = state_q;
      cnt_nx   = cnt_q;
      lsr_nx   = lsr_q;
      rsr_nx   = rsr_q;
      err_nx   = err_q;
      done_nx  = 1'b0;
      if (bck_rise) begin
         case (state_q)
            S_IDLE: begin
               if (slot_lvl && !lvl_prev) begin
                  state_nx = S_LEFT;
                  lsr_nx   = msb_word;
                  cnt_nx   = CNT_W'(1);
                  err_nx   = 1'b0;
               end
            end
            S_LEFT: begin
               if (!slot_lvl) begin
                  state_nx = S_RIGHT;
                  rsr_nx   = msb_word;
                  cnt_nx   = CNT_W'(1);
                  err_nx   = (cnt_q != CNT_FULL);
               end else if (cnt_q != CNT_FULL) begin
                  lsr_nx = lsr_q | bit_word;
                  cnt_nx = cnt_q + CNT_W'(1);
               end
            end
            S_RIGHT: begin
               if (slot_lvl) begin
                  done_nx  = 1'b1;
                  state_nx = S_LEFT;
                  lsr_nx   = msb_word;
                  cnt_nx   = CNT_W'(1);
                  err_nx   = 1'b0;
               end else if (cnt_q != CNT_FULL) begin
                  rsr_nx = rsr_q | bit_word;
                  cnt_nx = cnt_q + CNT_W'(1);
               end
            end
            default: state_nx = S_IDLE;
         endcase
      end else if (stall_cnt == '0) begin
         state_nx = S_IDLE;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         lsr_q    <= '0;
         rsr_q    <= '0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         pair_l   <= '0;
         pair_r   <= '0;
         pair_err <= 1'b0;
      end else begin
         state_q <= state_nx;
         cnt_q   <= cnt_nx;
         lsr_q   <= lsr_nx;
         rsr_q   <= rsr_nx;
         err_q   <= err_nx;
         done_q  <= done_nx;
         if (done_nx) begin
            pair_l   <= lsr_q;
            pair_r   <= rsr_q;
            pair_err <= err_q | (cnt_q != CNT_FULL);
         end
      end
   end

   // Pair is staged one cycle after frame completion so a held pair is never disturbed
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_left_sample  <= '0;
         o_right_sample <= '0;
         o_valid        <= 1'b0;
         o_frame_err    <= 1'b0;
         o_overrun      <= 1'b0;
         o_locked       <= 1'b0;
      end else begin
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
         if (o_valid && i_ready) o_valid <= 1'b0;
         if (state_q == S_IDLE) o_locked <= 1'b0;
         if (done_q) begin
            if (!o_valid || i_ready) begin
               o_left_sample  <= pair_l;
               o_right_sample <= pair_r;
               o_valid        <= 1'b1;
               o_frame_err    <= pair_err;
               o_locked       <= 1'b1;
            end else begin
               o_overrun <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_adc_serial_rx.sv
// Scoreboard bench for adc_serial_rx: a MODE 0 and a MODE 1 instance share the serial lines,
// expected pairs are queued at stimulus time and popped by per-instance monitors.
module tb_adc_serial_rx;
   localparam int DW = 24;

   logic clk = 1'b0, rst_n = 1'b0, bck = 1'b0, lrck = 1'b0, sd = 1'b0, ready = 1'b1;
   logic en0 = 1'b0, en1 = 1'b0;
   logic [DW-1:0] l0, r0, l1, r1;
   logic v0, v1, fe0, fe1, ov0, ov1, lk0, lk1;

   int n_cmp = 0, n_bad = 0, ov_cnt0 = 0, ov_cnt1 = 0;
   logic [48:0] q0[$], q1[$];
   logic [48:0] e0, e1;
   logic err_seen0 = 1'b0, err_seen1 = 1'b0;

   always #5 clk = ~clk;

   adc_serial_rx #(.DATA_W(DW), .MODE(0), .SYNC_STAGES(2)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_bck(bck & en0), .i_lrck(lrck), .i_serial_data(sd),
      .i_ready(ready), .o_left_sample(l0), .o_right_sample(r0), .o_valid(v0),
      .o_frame_err(fe0), .o_overrun(ov0), .o_locked(lk0));

   adc_serial_rx #(.DATA_W(DW), .MODE(1), .SYNC_STAGES(2)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_bck(bck & en1), .i_lrck(lrck), .i_serial_data(sd),
      .i_ready(ready), .o_left_sample(l1), .o_right_sample(r1), .o_valid(v1),
      .o_frame_err(fe1), .o_overrun(ov1), .o_locked(lk1));

   always @(negedge clk) begin
      if (!rst_n) err_seen0 = 1'b0;
      else begin
         if (fe0) err_seen0 = 1'b1;
         if (ov0) ov_cnt0++;
         if (v0 && ready) begin
            n_cmp++;
            if (q0.size() == 0) begin
               n_bad++;
               $display("FAIL dut0_unexpected_pair: got err=%b L=%h R=%h, want no pair", err_seen0, l0, r0);
            end else begin
               e0 = q0.pop_front();
               if ({err_seen0, l0, r0} !== e0) begin
                  n_bad++;
                  $display("FAIL dut0_pair: got err=%b L=%h R=%h, want err=%b L=%h R=%h",
                           err_seen0, l0, r0, e0[48], e0[47:24], e0[23:0]);
               end
            end
            err_seen0 = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) err_seen1 = 1'b0;
      else begin
         if (fe1) err_seen1 = 1'b1;
         if (ov1) ov_cnt1++;
         if (v1 && ready) begin
            n_cmp++;
            if (q1.size() == 0) begin
               n_bad++;
               $display("FAIL dut1_unexpected_pair: got err=%b L=%h R=%h, want no pair", err_seen1, l1, r1);
            end else begin
               e1 = q1.pop_front();
               if ({err_seen1, l1, r1} !== e1) begin
                  n_bad++;
                  $display("FAIL dut1_pair: got err=%b L=%h R=%h, want err=%b L=%h R=%h",
                           err_seen1, l1, r1, e1[48], e1[47:24], e1[23:0]);
               end
            end
            err_seen1 = 1'b0;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bck_cyc(input logic lr, input logic d);
      lrck = lr;
      sd   = d;
      #40 bck = 1'b1;
      #40 bck = 1'b0;
   endtask

   // mode 1 puts the MSB one BCK after the slot edge; bit 0 of the slot carries padding
   task automatic send_slot(input int mode, input logic lr, input logic [31:0] word,
                            input int w, input int nbck);
      for (int i = 0; i < nbck; i++) begin
         int   k;
         logic b;
         k = (mode == 1) ? i - 1 : i;
         b = (k >= 0 && k < w) ? word[w-1-k] : 1'b0;
         bck_cyc(lr, b);
      end
   endtask

   task automatic send_frame(input int mode, input logic [31:0] lw, input logic [31:0] rw,
                             input int w, input int nbck);
      logic left_lvl;
      left_lvl = (mode == 0) ? 1'b1 : 1'b0;
      send_slot(mode, left_lvl, lw, w, nbck);
      send_slot(mode, ~left_lvl, rw, w, nbck);
   endtask

   task automatic lead_in(input int mode);
      repeat (2) bck_cyc((mode == 0) ? 1'b0 : 1'b1, 1'b0);
   endtask

   task automatic tail(input int mode);
      repeat (2) bck_cyc((mode == 0) ? 1'b1 : 1'b0, 1'b0);
   endtask

   task automatic settle();
      repeat (20) step();
   endtask

   task automatic do_reset(input string nm);
      rst_n = 1'b0;
      repeat (3) step();
      chk({nm, "_dut0_outputs"}, 64'({v0, fe0, ov0, lk0, l0, r0}), 64'd0);
      chk({nm, "_dut1_outputs"}, 64'({v1, fe1, ov1, lk1, l1, r1}), 64'd0);
      rst_n = 1'b1;
      ov_cnt0 = 0;
      ov_cnt1 = 0;
      repeat (4) step();
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      step();
      // T1: left-justified, 32 BCK per slot
      en0 = 1'b1; en1 = 1'b0; ready = 1'b1;
      do_reset("t1_reset");
      q0.push_back({1'b0, 24'h123456, 24'hABCDEF});
      lead_in(0);
      send_frame(0, 32'h123456, 32'hABCDEF, 24, 32);
      tail(0);
      settle();
      chk("t1_locked", 64'(lk0), 64'd1);
      chk("t1_overruns", 64'(ov_cnt0), 64'd0);
      chk("t1_drained", 64'(q0.size()), 64'd0);

      // T2: I2S stream into both modes; MODE 0 sees each word shifted by one bit
      en0 = 1'b1; en1 = 1'b1;
      do_reset("t2_reset");
      q1.push_back({1'b0, 24'h123456, 24'hABCDEF});
      q1.push_back({1'b0, 24'h123456, 24'hABCDEF});
      q0.push_back({1'b0, 24'h55E6F7, 24'h091A2B});
      lead_in(1);
      send_frame(1, 32'h123456, 32'hABCDEF, 24, 32);
      send_frame(1, 32'h123456, 32'hABCDEF, 24, 32);
      tail(1);
      settle();
      chk("t2_dut1_drained", 64'(q1.size()), 64'd0);
      chk("t2_dut0_drained", 64'(q0.size()), 64'd0);

      // T3: back-pressure across two frames
      en1 = 1'b0; ready = 1'b0;
      do_reset("t3_reset");
      q0.push_back({1'b0, 24'h000001, 24'h7FFFFF});
      lead_in(0);
      send_frame(0, 32'h000001, 32'h7FFFFF, 24, 32);
      send_frame(0, 32'h800000, 32'hFFFFFF, 24, 32);
      tail(0);
      settle();
      chk("t3_overruns", 64'(ov_cnt0), 64'd1);
      chk("t3_held_valid", 64'(v0), 64'd1);
      chk("t3_held_left", 64'(l0), 64'h000001);
      ready = 1'b1;
      settle();
      chk("t3_drained", 64'(q0.size()), 64'd0);
      chk("t3_valid_cleared", 64'(v0), 64'd0);

      // T4: short 16-BCK slots zero-fill the LSBs and flag a frame error
      do_reset("t4_reset");
      q0.push_back({1'b1, 24'hA5A500, 24'h123400});
      lead_in(0);
      send_frame(0, 32'hA5A5, 32'h1234, 16, 16);
      tail(0);
      settle();
      chk("t4_drained", 64'(q0.size()), 64'd0);

      // T5: start mid-right slot, reset mid-left slot; partial frames must vanish
      do_reset("t5_reset");
      send_slot(0, 1'b0, 32'hFFFFFF, 24, 10);
      send_slot(0, 1'b1, 32'h777777, 24, 12);
      rst_n = 1'b0;
      repeat (3) bck_cyc(1'b1, 1'b1);
      chk("t5_in_reset_dut0", 64'({v0, fe0, ov0, lk0, l0, r0}), 64'd0);
      rst_n = 1'b1;
      repeat (7) bck_cyc(1'b1, 1'b1);
      send_slot(0, 1'b0, 32'h555555, 24, 32);
      q0.push_back({1'b0, 24'h3C3C3C, 24'h0F0F0F});
      send_frame(0, 32'h3C3C3C, 32'h0F0F0F, 24, 32);
      tail(0);
      settle();
      chk("t5_drained", 64'(q0.size()), 64'd0);

      // T6: BCK stall drops lock; restart recovers
      do_reset("t6_reset");
      q0.push_back({1'b0, 24'h13579B, 24'h2468AC});
      lead_in(0);
      send_frame(0, 32'h13579B, 32'h2468AC, 24, 32);
      tail(0);
      settle();
      chk("t6_locked_before_stall", 64'(lk0), 64'd1);
      repeat (4300) step();
      chk("t6_unlocked_after_stall", 64'(lk0), 64'd0);
      q0.push_back({1'b0, 24'hFEDCBA, 24'h012345});
      lead_in(0);
      send_frame(0, 32'hFEDCBA, 32'h012345, 24, 32);
      tail(0);
      settle();
      chk("t6_relocked", 64'(lk0), 64'd1);
      chk("t6_drained", 64'(q0.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
